// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of pending stores drained to data memory by a
// two-state FSM, with optional load forwarding.
// Build option: define STORE_BUF_FWD_EN to enable store-to-load forwarding;
// without it, loads stall the pipeline until the buffer is empty.
module store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    input  logic                       ld_valid,
    input  logic [AW-1:0]              ld_addr,
    output logic                       ld_hit,
    output logic [DW-1:0]              ld_data,
    output logic                       stall_req,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       mem_req,
    output logic [AW-1:0]              mem_addr,
    output logic [DW-1:0]              mem_wdata,
    input  logic                       mem_ack
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   addr_q [DEPTH];
    logic [DW-1:0]   data_q [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            push, pop;
    logic [CW-1:0]   count_next;

    // Full is registered, so a pop in a full cycle frees a slot only for the next cycle.
    assign push       = st_valid && !full;
    assign pop        = (state == BUSY) && mem_ack;
    assign count_next = count + CW'(push) - CW'(pop);

    // Drain FSM next state: leave IDLE as soon as an entry lands, return when the last one pops.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (count_next != '0) state_next = BUSY;
            BUSY:    if (count_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Drain FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Pointers, occupancy count and registered flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == CW'(DEPTH));
        end
    end

    // Entry storage; contents are don't-care until counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= st_addr;
            data_q[wr_ptr] <= st_data;
        end
    end

    assign mem_req   = (state == BUSY);
    assign mem_addr  = (state == BUSY) ? addr_q[rd_ptr] : '0;
    assign mem_wdata = (state == BUSY) ? data_q[rd_ptr] : '0;

`ifdef STORE_BUF_FWD_EN
    logic [PW-1:0] fwd_idx;
    logic          unused_ld_lo;

    assign unused_ld_lo = ^ld_addr[1:0];
    assign stall_req    = st_valid && full;

    // Forwarding search from oldest to youngest so the youngest word match wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr + PW'(i);
            if (ld_valid && (CW'(i) < count) &&
                (addr_q[fwd_idx][AW-1:2] == ld_addr[AW-1:2])) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fwd_idx];
            end
        end
    end
`else
    logic unused_ld;

    assign unused_ld = ^ld_addr;
    assign ld_hit    = 1'b0;
    assign ld_data   = '0;
    assign stall_req = (st_valid && full) || (ld_valid && !empty);
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a queue-based reference model predicts
// every output each cycle; directed scenarios plus a randomized run.
module tb_store_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned CW    = $clog2(DEPTH+1);
    localparam int unsigned VW    = CW + AW + 2*DW + 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          stall_req;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending stores, oldest at index 0.
    logic [AW-1:0] qa[$];
    logic [DW-1:0] qd[$];
    bit            busy = 0;

    logic [VW-1:0] act_v, exp_v;

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .ld_valid(ld_valid), .ld_addr(ld_addr),
        .ld_hit(ld_hit), .ld_data(ld_data), .stall_req(stall_req),
        .full(full), .empty(empty), .count(count),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        st_valid = 0; st_addr = '0; st_data = '0;
        ld_valid = 0; ld_addr = '0; mem_ack = 0;
    endtask

    // Settle, then build the observed and predicted output vectors.
    task automatic sample();
        logic [CW-1:0] e_count;
        logic          e_full, e_empty, e_stall, e_hit;
        logic [AW-1:0] e_maddr, a;
        logic [DW-1:0] e_mdata, e_ldata;
        #2;
        e_count = CW'(qa.size());
        e_full  = (qa.size() == DEPTH);
        e_empty = (qa.size() == 0);
        e_maddr = busy ? qa[0] : '0;
        e_mdata = busy ? qd[0] : '0;
        e_hit   = 0;
        e_ldata = '0;
`ifdef STORE_BUF_FWD_EN
        if (ld_valid)
            for (int i = 0; i < qa.size(); i++) begin
                a = qa[i];
                if (a[AW-1:2] == ld_addr[AW-1:2]) begin
                    e_hit = 1; e_ldata = qd[i];
                end
            end
        e_stall = st_valid && e_full;
`else
        a = '0;
        e_stall = (st_valid && e_full) || (ld_valid && !e_empty);
`endif
        act_v = {count, full, empty, mem_req, mem_addr, mem_wdata, stall_req, ld_hit, ld_data};
        exp_v = {e_count, e_full, e_empty, busy, e_maddr, e_mdata, e_stall, e_hit, e_ldata};
    endtask

    // Advance the model and the clock by one cycle using the inputs now driven.
    task automatic tick();
        bit push, pop;
        push = st_valid && (qa.size() != DEPTH);
        pop  = busy && mem_ack;
        if (pop) begin void'(qa.pop_front()); void'(qd.pop_front()); end
        if (push) begin qa.push_back(st_addr); qd.push_back(st_data); end
        busy = (qa.size() != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #12;
        checks++;
        if ({count, full, empty, mem_req, mem_addr, ld_hit, ld_data} !==
            {CW'(0), 1'b0, 1'b1, 1'b0, AW'(0), 1'b0, DW'(0)}) begin
            errors++;
            $display("FAIL reset cnt=%0d full=%b empty=%b req=%b addr=%h hit=%b exp 0,0,1,0,0,0",
                     count, full, empty, mem_req, mem_addr, ld_hit);
        end
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_store();
        idle_inputs();
        mem_ack = 1;
        st_valid = 1; st_addr = 32'h100; st_data = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            sample();
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL single_store c=%0d act=%h exp=%h", c, act_v, exp_v);
            end
            checks++;
            if (c == 1 && {mem_req, mem_addr, mem_wdata, count} !== {1'b1, 32'h100, 32'hDEAD_BEEF, CW'(1)}) begin
                errors++; $display("FAIL single_store_req req=%b addr=%h data=%h exp 1,100,deadbeef", mem_req, mem_addr, mem_wdata);
            end else if (c >= 2 && {mem_req, count} !== {1'b0, CW'(0)}) begin
                errors++; $display("FAIL single_store_done req=%b cnt=%0d exp 0,0", mem_req, count);
            end
            tick();
            st_valid = 0;
        end
    endtask

    task automatic test_fill_stall();
        logic [AW-1:0] obs[$];
        int pushed = 0;
        int budget = 40;
        idle_inputs();
        while ((pushed < 5 || qa.size() != 0) && budget > 0) begin
            budget--;
            st_valid = (pushed < 5);
            st_addr  = 32'h1000 + 32'(pushed) * 4;
            st_data  = $urandom;
            sample();
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL fill_stall act=%h exp=%h", act_v, exp_v);
            end
            if (pushed == 4 && !mem_ack) begin
                checks++;
                if ({full, stall_req, count} !== {1'b1, 1'b1, CW'(4)}) begin
                    errors++; $display("FAIL fill_full full=%b stall=%b cnt=%0d exp 1,1,4", full, stall_req, count);
                end
                mem_ack = 1;
            end
            if (mem_req && mem_ack) obs.push_back(mem_addr);
            if (st_valid && qa.size() != DEPTH) pushed++;
            tick();
        end
        checks++;
        if (budget == 0 || obs.size() != 5) begin
            errors++; $display("FAIL fill_drain writes=%0d exp 5 budget=%0d", obs.size(), budget);
        end
        for (int i = 0; i < obs.size() && i < 5; i++) begin
            checks++;
            if (obs[i] !== 32'h1000 + 32'(i) * 4) begin
                errors++; $display("FAIL fill_order i=%0d act=%h exp=%h", i, obs[i], 32'h1000 + 32'(i) * 4);
            end
        end
    endtask

`ifdef STORE_BUF_FWD_EN
    task automatic test_forward();
        int budget = 20;
        idle_inputs();
        ld_valid = 1; ld_addr = 32'h202;
        for (int c = 0; c < 4; c++) begin
            st_valid = (c < 2);
            st_addr  = 32'h200;
            st_data  = (c == 0) ? 32'h11 : 32'h22;
            ld_addr  = (c == 3) ? 32'h300 : 32'h202;
            sample();
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL forward c=%0d act=%h exp=%h", c, act_v, exp_v);
            end
            checks++;
            if (c == 0 && ld_hit !== 1'b0) begin
                errors++; $display("FAIL fwd_same_cycle hit=%b exp 0", ld_hit);
            end else if (c == 2 && {ld_hit, ld_data} !== {1'b1, 32'h22}) begin
                errors++; $display("FAIL fwd_youngest hit=%b data=%h exp 1,22", ld_hit, ld_data);
            end else if (c == 3 && {ld_hit, ld_data} !== {1'b0, 32'h0}) begin
                errors++; $display("FAIL fwd_miss hit=%b data=%h exp 0,0", ld_hit, ld_data);
            end
            tick();
        end
        st_valid = 0; mem_ack = 1; ld_addr = 32'h200;
        while (qa.size() != 0 && budget > 0) begin
            budget--;
            sample();
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL fwd_drain act=%h exp=%h", act_v, exp_v);
            end
            tick();
        end
    endtask
`else
    task automatic test_no_forward();
        idle_inputs();
        st_valid = 1; st_addr = 32'h500; st_data = 32'h55;
        sample();
        tick();
        st_valid = 0; ld_valid = 1;
        for (int c = 0; c < 6; c++) begin
            ld_addr = (c == 0) ? 32'h500 : $urandom;
            mem_ack = (c == 3);
            sample();
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL no_fwd c=%0d act=%h exp=%h", c, act_v, exp_v);
            end
            checks++;
            if (c <= 3 && {ld_hit, stall_req} !== 2'b01) begin
                errors++; $display("FAIL no_fwd_stall c=%0d hit=%b stall=%b exp 0,1", c, ld_hit, stall_req);
            end else if (c > 3 && {ld_hit, stall_req, empty} !== 3'b001) begin
                errors++; $display("FAIL no_fwd_release c=%0d hit=%b stall=%b empty=%b exp 0,0,1", c, ld_hit, stall_req, empty);
            end
            tick();
        end
    endtask
`endif

    task automatic test_push_pop();
        int budget = 20;
        idle_inputs();
        for (int c = 0; c < 12; c++) begin
            st_valid = 1;
            st_addr  = 32'h3000 + 32'(c) * 4;
            st_data  = $urandom;
            mem_ack  = (c >= 2);
            sample();
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL push_pop c=%0d act=%h exp=%h", c, act_v, exp_v);
            end
            if (c >= 2) begin
                checks++;
                if ({count, mem_addr} !== {CW'(2), 32'h3000 + 32'(c - 2) * 4}) begin
                    errors++; $display("FAIL push_pop_cnt c=%0d cnt=%0d addr=%h exp 2,%h", c, count, mem_addr, 32'h3000 + 32'(c - 2) * 4);
                end
            end
            tick();
        end
        st_valid = 0; mem_ack = 1;
        while (qa.size() != 0 && budget > 0) begin
            budget--;
            sample();
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL push_pop_drain act=%h exp=%h", act_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            st_valid = 1; st_addr = 32'h4000 + 32'(c) * 4; st_data = $urandom;
            sample();
            tick();
        end
        st_valid = 0;
        sample();
        checks++;
        if ({mem_req, count} !== {1'b1, CW'(3)}) begin
            errors++; $display("FAIL reset_mid_pre req=%b cnt=%0d exp 1,3", mem_req, count);
        end
        rst_n = 0;
        #1;
        qa.delete(); qd.delete(); busy = 0;
        checks++;
        if ({mem_req, count, empty, full, mem_addr} !== {1'b0, CW'(0), 1'b1, 1'b0, AW'(0)}) begin
            errors++; $display("FAIL reset_mid_async req=%b cnt=%0d empty=%b full=%b exp 0,0,1,0", mem_req, count, empty, full);
        end
        #2;
        rst_n = 1;
        mem_ack = 1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) begin
            sample();
            checks++;
            if (act_v !== exp_v || mem_req !== 1'b0) begin
                errors++; $display("FAIL reset_mid_after c=%0d act=%h exp=%h", c, act_v, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int budget = 30;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            st_valid = ($urandom_range(0, 99) < 60);
            st_addr  = 32'h40 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            st_data  = $urandom;
            ld_valid = ($urandom_range(0, 99) < 50);
            ld_addr  = 32'h40 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            mem_ack  = ($urandom_range(0, 99) < 40);
            sample();
            checks++;
            if (act_v !== exp_v) begin
                errors++; $display("FAIL random c=%0d act=%h exp=%h", c, act_v, exp_v);
            end
            tick();
        end
        idle_inputs();
        mem_ack = 1;
        while (qa.size() != 0 && budget > 0) begin
            budget--;
            sample();
            tick();
        end
        sample();
        checks++;
        if (act_v !== exp_v || count !== CW'(0)) begin
            errors++; $display("FAIL random_drain act=%h exp=%h", act_v, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_fill_stall();
`ifdef STORE_BUF_FWD_EN
        test_forward();
`else
        test_no_forward();
`endif
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, entry count; SHALL be a power of two, 2..16.
REQ-002 Parameter AW, default 32, byte-address width.
REQ-003 Parameter DW, default 32, data width.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 st_valid  input  1  MEM-stage store request (mem_write_M).
REQ-007 st_addr  input  AW  store byte address (alu_result_M).
REQ-008 st_data  input  DW  store data (write_data_M).
REQ-009 ld_valid  input  1  MEM-stage load request.
REQ-010 ld_addr  input  AW  load byte address.
REQ-011 ld_hit  output  1  load matches a buffered entry; combinational.
REQ-012 ld_data  output  DW  forwarded data, valid when ld_hit=1, else 0.
REQ-013 stall_req  output  1  request to hazard unit to freeze F/D/E/M; combinational.
REQ-014 full / empty  output  1 each  occupancy flags, registered.
REQ-015 count  output  $clog2(DEPTH+1)  entries held, registered.
REQ-016 mem_req  output  1  write request to data memory, registered.
REQ-017 mem_addr / mem_wdata  output  AW / DW  head-entry address/data.
REQ-018 mem_ack  input  1  memory accepts the current write.

Function
REQ-019 SHALL hold a circular FIFO of DEPTH {addr, data} entries; wr_ptr and rd_ptr wrap modulo DEPTH.
REQ-020 Push SHALL occur when st_valid=1 and full=0; entry occupies the tail and count increments next edge.
REQ-021 When st_valid=1 and full=1, SHALL assert stall_req in the same cycle, drop nothing, and push on the first cycle full=0.
REQ-022 No same-cycle full bypass: a pop in the cycle the buffer is full does not admit a push until the following cycle.
REQ-023 Drain FSM states: IDLE (mem_req=0) and BUSY (mem_req=1).
REQ-024 IDLE->BUSY on the edge where empty=0; the first request is issued the cycle after the push (1-cycle latency).
REQ-025 In BUSY, mem_addr/mem_wdata SHALL equal the head entry and stay stable until mem_ack=1.
REQ-026 mem_ack=1 in BUSY SHALL pop the head; if count becomes 0 go to IDLE, else stay BUSY and present the next entry next cycle.
REQ-027 mem_ack while IDLE SHALL be ignored.
REQ-028 Simultaneous push and pop SHALL leave count unchanged and update both pointers.
REQ-029 Load match compares word address (addr[AW-1:2]) against all valid entries, including the head being drained.
REQ-030 Multiple matches: forward the youngest (closest to tail).
REQ-031 A store presented in the same cycle as a load is not visible to that load.
REQ-032 mem_addr/mem_wdata SHALL read 0 when IDLE.

Reset
REQ-033 On rst_n=0, immediately: pointers=0, count=0, empty=1, full=0, FSM=IDLE, mem_req=0, ld_hit=0, ld_data=0; buffered entries discarded.
REQ-034 Reset mid-transaction SHALL drop mem_req asynchronously without waiting for mem_ack.

Configuration
REQ-035 Macro STORE_BUF_FWD_EN defined: load forwarding per REQ-029..031.
REQ-036 Macro undefined: ld_hit=0 and ld_data=0 always; stall_req also asserts when ld_valid=1 and empty=0, until the buffer drains.

Verification
REQ-037 Single store 0x100/0xDEAD_BEEF, mem_ack tied 1 -> mem_req high one cycle later for 1 cycle, addr 0x100, count returns 0.
REQ-038 Five back-to-back stores, DEPTH=4, mem_ack=0 -> full=1 after 4, stall_req=1 on the 5th; raise ack -> 5th pushed after one pop, memory sees all 5 in order.
REQ-039 Stores 0x200=0x11 then 0x200=0x22, load 0x202 with ack held 0 -> ld_hit=1, ld_data=0x22 (youngest wins); load 0x300 -> ld_hit=0.
REQ-040 Push and ack in the same cycle with count=2 -> count stays 2, pointers advance, wrap past DEPTH-1 correct.
REQ-041 Assert rst_n=0 while mem_req=1, count=3 -> mem_req=0 and count=0 without a clock edge; no write issued after release.
REQ-042 Build without STORE_BUF_FWD_EN, 1 store pending, load any address -> ld_hit=0, stall_req=1 until mem_ack pops the entry.
